// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory bus between data access and instruction fetch.
// Optional single-entry fetch buffer enabled by defining FETCH_BUF_EN.
module mem_arbiter #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    i_iaddr,
  output logic [DW-1:0]    o_inst,
  input  logic             i_read_en,
  input  logic             i_write_en,
  input  logic [AW-1:0]    i_daddr,
  input  logic [DW-1:0]    i_wdata,
  output logic [DW-1:0]    o_read_data,
  output logic             o_exstall,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [AW-1:0]    o_mem_addr,
  output logic [DW-1:0]    o_mem_wdata,
  input  logic             i_mem_ack,
  input  logic [DW-1:0]    i_mem_rdata,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, FETCH, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] iaddr_q, daddr_q;
  logic [DW-1:0] wdata_q;
  logic          wr_q, rd_q;
  logic          hit_idle, hit_data;

  // Bus is driven purely from captured step values.
  assign o_mem_req   = (state == DATA) || (state == FETCH);
  assign o_mem_we    = (state == DATA) && wr_q;
  assign o_mem_addr  = (state == DATA) ? daddr_q : iaddr_q;
  assign o_mem_wdata = wdata_q;
  assign o_exstall   = (state != RELEASE);

`ifdef FETCH_BUF_EN
  logic [AW-1:0] tag;
  logic          tag_vld;
  logic          wr_inval;

  // A store hitting the buffered PC must invalidate before the fetch decision.
  assign wr_inval = (state == DATA) && wr_q && i_mem_ack && (daddr_q == tag);
  assign hit_idle = tag_vld && (i_iaddr == tag);
  assign hit_data = tag_vld && !wr_inval && (iaddr_q == tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      tag     <= '0;
      tag_vld <= 1'b0;
    end else if ((state == FETCH) && i_mem_ack) begin
      tag     <= iaddr_q;
      tag_vld <= 1'b1;
    end else if (wr_inval) begin
      tag_vld <= 1'b0;
    end
  end
`else
  assign hit_idle = 1'b0;
  assign hit_data = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_read_en || i_write_en) state_nxt = DATA;
        else if (hit_idle)           state_nxt = RELEASE;
        else                         state_nxt = FETCH;
      end
      DATA:    if (i_mem_ack) state_nxt = hit_data ? RELEASE : FETCH;
      FETCH:   if (i_mem_ack) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iaddr_q <= '0;
      daddr_q <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else if (state == IDLE) begin
      iaddr_q <= i_iaddr;
      daddr_q <= i_daddr;
      wdata_q <= i_wdata;
      wr_q    <= i_write_en;
      rd_q    <= i_read_en && !i_write_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_inst      <= DW'(32'h0000_0013);
      o_read_data <= '0;
    end else begin
      if ((state == FETCH) && i_mem_ack)        o_inst      <= i_mem_rdata;
      if ((state == DATA) && rd_q && i_mem_ack) o_read_data <= i_mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          o_stall_cnt <= '0;
    else if (o_exstall && !(&o_stall_cnt)) o_stall_cnt <= o_stall_cnt + 1'b1;
  end

endmodule
